// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM.
// Per-opcode state paths drive datapath enables and mux selects. Also provides
// a memory ready handshake with a wait timeout, a sticky trap for illegal
// opcodes and memory timeouts, and an instruction retire counter.
module multicycle_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned HAS_JALR       = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             carry,
    input  logic             sign,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WR = 4'd4;
    localparam logic [3:0] S_MEM_WB = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8;
    localparam logic [3:0] S_JAL    = 4'd9;
    localparam logic [3:0] S_JALR1  = 4'd10;
    localparam logic [3:0] S_JALR2  = 4'd11;
    localparam logic [3:0] S_BRANCH = 4'd12;
    localparam logic [3:0] S_UPPER  = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int unsigned WC_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WC_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WC_LAST_I);

    logic [3:0]      state;
    logic [3:0]      next_state;
    logic [WC_W-1:0] wait_cnt;
    logic            go_trap;
    logic [1:0]      cause_nxt;
    logic            in_wait;
    logic            timeout_hit;
    logic            br_legal;
    logic            br_taken;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            req_r;
    logic            wr_r;
    logic            irw_r;
    logic            pcw_r;
    logic            rw_r;
    logic            ret_r;
    logic            unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    assign in_wait     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_wait && !mem_ready && (wait_cnt == WC_LAST);

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    // Branch condition from ALU flags; funct3 010/011 are not branches.
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = sign ^ overflow;
            3'b101:  br_taken = !(sign ^ overflow);
            3'b110:  br_taken = !carry;
            3'b111:  br_taken = carry;
            default: br_legal = 1'b0;
        endcase
    end

    // Next-state selection, including trap entry and its cause.
    always_comb begin
        next_state = state;
        go_trap    = 1'b0;
        cause_nxt  = CAUSE_NONE;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_IMM:            next_state = S_EXEC_I;
                    OP_JAL:            next_state = S_JAL;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                    OP_JALR: begin
                        if (HAS_JALR != 0) begin
                            next_state = S_JALR1;
                        end else begin
                            go_trap   = 1'b1;
                            cause_nxt = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        go_trap   = 1'b1;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR: if (mem_ready) next_state = S_FETCH;
            S_MEM_WB: next_state = S_FETCH;
            S_EXEC_R: next_state = S_ALU_WB;
            S_EXEC_I: next_state = S_ALU_WB;
            S_ALU_WB: next_state = S_FETCH;
            S_JAL:    next_state = S_ALU_WB;
            S_JALR1:  next_state = S_JALR2;
            S_JALR2:  next_state = S_ALU_WB;
            S_BRANCH: begin
                if (br_legal) begin
                    next_state = S_FETCH;
                end else begin
                    go_trap   = 1'b1;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            S_UPPER:  next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
        if (timeout_hit) begin
            go_trap   = 1'b1;
            cause_nxt = CAUSE_TIMEOUT;
        end
        if (go_trap) next_state = S_TRAP;
    end

    // Per-state datapath controls; unlisted controls stay zero.
    always_comb begin
        req_r      = 1'b0;
        wr_r       = 1'b0;
        irw_r      = 1'b0;
        pcw_r      = 1'b0;
        rw_r       = 1'b0;
        ret_r      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state)
            S_FETCH: begin
                req_r      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw_r      = mem_ready;
                pcw_r      = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                req_r   = 1'b1;
                adr_src = 1'b1;
            end
            S_MEM_WR: begin
                req_r   = 1'b1;
                wr_r    = 1'b1;
                adr_src = 1'b1;
                ret_r   = mem_ready;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                rw_r       = 1'b1;
                ret_r      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                rw_r  = 1'b1;
                ret_r = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw_r     = 1'b1;
            end
            S_JALR1: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_JALR2: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pcw_r      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pcw_r     = br_legal & br_taken;
                ret_r     = br_legal;
            end
            S_UPPER: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                rw_r       = 1'b1;
                ret_r      = 1'b1;
                if (opcode == OP_AUIPC) begin
                    alu_src_a = 2'b01;
                end else begin
                    alu_op = 2'b11;
                end
            end
            default: ;
        endcase
    end

    // Enables are masked by reset so an access in flight drops immediately.
    assign mem_req   = req_r & rst_n;
    assign mem_write = wr_r  & rst_n;
    assign ir_write  = irw_r & rst_n;
    assign pc_write  = pcw_r & rst_n;
    assign reg_write = rw_r  & rst_n;
    assign retire    = ret_r & rst_n;

    // State register and memory wait counter (cleared whenever the state changes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Sticky trap flag and cause; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else if (go_trap) begin
            trap       <= 1'b1;
            trap_cause <= cause_nxt;
        end
    end

    // Retired-instruction counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (ret_r) begin
            instret <= instret + 1'b1;
        end
    end

endmodule
